// File: rtl/multimode_reg.sv
// rtl/multimode_reg.sv - WIDTH-bit register with hold/load/shift/rotate/count modes
// Provides complementary outputs, serial taps, terminal-count detect and a registered wrap pulse.
module multimode_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             tc_c;

    // Terminal count looks at the current mode, so it is valid before the edge that wraps.
    always_comb begin
        tc_c = ((mode == 3'b110) && (&q_q)) || ((mode == 3'b111) && (q_q == '0));
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (en) begin
            wrap_d = tc_c;
            case (mode)
                3'b001:  q_d = d;
                3'b010:  q_d = {q_q[WIDTH-2:0], sin_r};
                3'b011:  q_d = {sin_l, q_q[WIDTH-1:1]};
                3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                3'b110:  q_d = q_q + ONE;
                3'b111:  q_d = q_q - ONE;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q      = q_q;
    assign qbar   = ~q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign tc     = tc_c;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_multimode_reg.sv
// tb/tb_multimode_reg.sv - scoreboard bench for multimode_reg
// Stimulus queues expected results; a monitor compares them after each rising edge.
module tb_multimode_reg;

    logic       clk = 1'b0;
    logic       clear, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q, qbar, q2, qbar2;
    logic       sout_l, sout_r, tc, wrap;
    logic       sout_l2, sout_r2, tc2, wrap2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       w;
        logic       tc;
        logic       chk_q2;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    multimode_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .clear(clear), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .qbar(qbar),
        .sout_l(sout_l), .sout_r(sout_r), .tc(tc), .wrap(wrap)
    );

    multimode_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut2 (
        .clk(clk), .clear(clear), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q2), .qbar(qbar2),
        .sout_l(sout_l2), .sout_r(sout_r2), .tc(tc2), .wrap(wrap2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: the register presents a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (en === 1'b1 && clear === 1'b0 && $isunknown(mode)) begin
                total++;
                bad++;
                $display("FAIL mode_x: mode=%b with en=1", mode);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", q, e.q);
                chk("qbar", qbar, ~e.q);
                chk("sout_l", {7'd0, sout_l}, {7'd0, e.q[7]});
                chk("sout_r", {7'd0, sout_r}, {7'd0, e.q[0]});
                chk("tc", {7'd0, tc}, {7'd0, e.tc});
                chk("wrap", {7'd0, wrap}, {7'd0, e.w});
                if (e.chk_q2) chk("q_rv3c", q2, 8'h3C);
            end
        end
    end

    task automatic step(input logic c, input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic sl, input logic sr,
                        input logic [7:0] eq, input logic ew, input logic etc, input logic c2);
        exp_t x;
        @(negedge clk);
        #1;
        clear = c; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
        x.q = eq; x.w = ew; x.tc = etc; x.chk_q2 = c2;
        sb.push_back(x);
    endtask

    function automatic logic tc_of(input logic [2:0] m, input logic [7:0] v);
        return (m == 3'b110 && v == 8'hFF) || (m == 3'b111 && v == 8'h00);
    endfunction

    initial begin
        logic [7:0] mq, nq;
        logic       nw;
        logic       rc, re, rsl, rsr;
        logic [2:0] rm;
        logic [7:0] rd;
        int         guard;

        clear = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

        // reset, arbitrary state, reset again with load pending
        step(1, 1, 3'b001, 8'hA5, 0, 0, 8'h00, 0, 0, 1);
        step(0, 1, 3'b001, 8'h5A, 0, 0, 8'h5A, 0, 0, 0);
        step(1, 1, 3'b001, 8'hA5, 0, 0, 8'h00, 0, 0, 1);
        // load and shifts
        step(0, 1, 3'b001, 8'hB4, 0, 0, 8'hB4, 0, 0, 0);
        step(0, 1, 3'b010, 8'h00, 0, 1, 8'h69, 0, 0, 0);
        step(0, 1, 3'b011, 8'h00, 0, 1, 8'h34, 0, 0, 0);
        // rotate
        step(0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0, 0);
        step(0, 1, 3'b100, 8'h00, 0, 0, 8'h03, 0, 0, 0);
        step(0, 1, 3'b101, 8'h00, 0, 0, 8'h81, 0, 0, 0);
        step(0, 1, 3'b101, 8'h00, 0, 0, 8'hC0, 0, 0, 0);
        // count wrap up and down
        step(0, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0, 0, 0);
        step(0, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 0, 1, 0);
        step(0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        step(0, 1, 3'b110, 8'h00, 0, 0, 8'h01, 0, 0, 0);
        step(0, 1, 3'b111, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        step(0, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 1, 0, 0);
        // enable low holds, clear beats a wrapping count
        for (int i = 0; i < 5; i++) step(0, 0, 3'b110, 8'h55, 1, 1, 8'hFF, 0, 1, 0);
        step(1, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        step(0, 1, 3'b110, 8'h00, 0, 0, 8'h01, 0, 0, 0);

        // random against reference model
        mq = 8'h01;
        for (int i = 0; i < 2000; i++) begin
            rc  = ($urandom_range(0, 19) == 0);
            re  = ($urandom_range(0, 3) != 0);
            rm  = 3'($urandom_range(0, 7));
            rd  = 8'($urandom);
            rsl = 1'($urandom);
            rsr = 1'($urandom);
            if (rc) begin
                nq = 8'h00; nw = 1'b0;
            end else if (!re) begin
                nq = mq; nw = 1'b0;
            end else begin
                nw = tc_of(rm, mq);
                case (rm)
                    3'd0: nq = mq;
                    3'd1: nq = rd;
                    3'd2: nq = {mq[6:0], rsr};
                    3'd3: nq = {rsl, mq[7:1]};
                    3'd4: nq = {mq[6:0], mq[7]};
                    3'd5: nq = {mq[0], mq[7:1]};
                    3'd6: nq = mq + 8'd1;
                    default: nq = mq - 8'd1;
                endcase
            end
            step(rc, re, rm, rd, rsl, rsr, nq, nw, tc_of(rm, nq), 1'b0);
            mq = nq;
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #5;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
